// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM state encoding,
// product/sum width helpers and the reduction of a full-precision dot
// product to the output element width.
// Build option: define MATMUL_SAT_EN to clamp instead of wrapping.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } seqState_t;

    // Widths for the default configuration (4-bit A, 8-bit B, 4 features).
    localparam int PROD_WIDTH = 4 + 8;
    localparam int SUM_WIDTH  = PROD_WIDTH + 2;

    function automatic int prodWidth(input int inputWidth, input int weightWidth);
        return inputWidth + weightWidth;
    endfunction

    function automatic int sumWidth(input int inputWidth, input int weightWidth,
                                    input int logFeatures);
        return inputWidth + weightWidth + logFeatures;
    endfunction

    // Reduce a sign-extended full-precision sum to outW bits. The result is
    // returned sign-extended to 64 bits; the caller keeps the low outW bits.
    function automatic logic signed [63:0] reduceSum(input logic signed [63:0] sum,
                                                     input int outW);
`ifdef MATMUL_SAT_EN
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (outW - 1));
        if (sum > maxV) begin
            return maxV;
        end else if (sum < minV) begin
            return minV;
        end
        return sum;
`else
        logic signed [63:0] shifted;
        shifted = sum <<< (64 - outW);
        return shifted >>> (64 - outW);
`endif
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Memory and host-control bundle of the matrix-multiply sequencer.
// master: the sequencer. slave: memories plus host control.
interface matmul_sequencer_if #(
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int INPUT_FEATURES      = 4,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int INPUT_WIDTH         = 4,
    parameter int WEIGHT_WIDTH        = 8,
    parameter int OUTPUT_WIDTH        = 16
) ();

    logic                                      start;
    logic                                      busy;
    logic                                      done;
    logic [LOG_BATCH_SIZE-1:0]                 inputAddr;
    logic [INPUT_FEATURES*INPUT_WIDTH-1:0]     inputData;
    logic [LOG_OUTPUT_FEATURES-1:0]            weightAddr;
    logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0]    weightData;
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]   outputData;
    logic [LOG_BATCH_SIZE-1:0]                 outputAddr;
    logic                                      outputWrEn;

    modport master (
        input  start, inputData, weightData,
        output busy, done, inputAddr, weightAddr, outputData, outputAddr, outputWrEn
    );

    modport slave (
        output start, inputData, weightData,
        input  busy, done, inputAddr, weightAddr, outputData, outputAddr, outputWrEn
    );

endinterface

// File: rtl/matmul_sequencer_dpu.sv
// dot_product_unit: N signed multipliers feeding a full-precision sum,
// registered once (one-cycle latency). The sum is never truncated here.
module dot_product_unit
    import matmul_pkg::*;
#(
    parameter int INPUT_FEATURES     = 4,
    parameter int LOG_INPUT_FEATURES = 2,
    parameter int INPUT_WIDTH        = 4,
    parameter int WEIGHT_WIDTH       = 8,
    localparam int PW = prodWidth(INPUT_WIDTH, WEIGHT_WIDTH),
    localparam int SW = sumWidth(INPUT_WIDTH, WEIGHT_WIDTH, LOG_INPUT_FEATURES)
) (
    input  logic                                   clk,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]  inputRow,
    input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0] weightRow,
    output logic signed [SW-1:0]                   dotSum
);

    logic signed [INPUT_WIDTH-1:0]  aLane [INPUT_FEATURES];
    logic signed [WEIGHT_WIDTH-1:0] wLane [INPUT_FEATURES];
    logic signed [PW-1:0]           prod  [INPUT_FEATURES];
    logic signed [SW-1:0]           sumComb;

    // Split lanes, multiply each pair and accumulate at full width.
    always_comb begin
        sumComb = '0;
        for (int k = 0; k < INPUT_FEATURES; k++) begin
            aLane[k] = inputRow[k*INPUT_WIDTH +: INPUT_WIDTH];
            wLane[k] = weightRow[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            prod[k]  = PW'(aLane[k]) * PW'(wLane[k]);
            sumComb  = sumComb + SW'(prod[k]);
        end
    end

    // Output register; pure datapath, validity is tracked by the sequencer.
    always_ff @(posedge clk) begin
        dotSum <= sumComb;
    end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks rows of A and rows of B-transpose through the
// dot-product unit, collects one row of C in a row buffer and writes it out.
// Build option: MATMUL_SAT_EN selects saturation instead of wrap when the
// full-precision sum is reduced to OUTPUT_WIDTH (see matmul_pkg).
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int INPUT_FEATURES      = 4,
    parameter int LOG_INPUT_FEATURES  = 2,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int INPUT_WIDTH         = 4,
    parameter int WEIGHT_WIDTH        = 8,
    parameter int OUTPUT_WIDTH        = 16
) (
    input logic                clk,
    input logic                rst,
    matmul_sequencer_if.master bus
);

    localparam int SUM_W = sumWidth(INPUT_WIDTH, WEIGHT_WIDTH, LOG_INPUT_FEATURES);
    localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

    seqState_t                                state;
    seqState_t                                stateNext;
    logic [LOG_BATCH_SIZE-1:0]                rowCnt;
    logic [LOG_OUTPUT_FEATURES-1:0]           colCnt;
    logic                                     drainDone;
    logic                                     busyComb;
    logic                                     doneComb;
    logic                                     wrEnComb;

    logic                                     vld_p0;
    logic                                     vld_p1;
    logic                                     vld_p2;
    logic [LOG_OUTPUT_FEATURES-1:0]           col_p1;
    logic [LOG_OUTPUT_FEATURES-1:0]           col_p2;
    logic signed [SUM_W-1:0]                  dotSum_p2;
    logic signed [63:0]                       sumExt_p2;
    logic signed [OUTPUT_WIDTH-1:0]           elem_p2;
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]  rowBuf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and the strobes that follow directly from the state.
    always_comb begin
        stateNext = state;
        busyComb  = 1'b0;
        doneComb  = 1'b0;
        wrEnComb  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                busyComb  = 1'b1;
                stateNext = STREAM;
            end
            STREAM: begin
                busyComb = 1'b1;
                if (colCnt == LAST_COL) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                busyComb = 1'b1;
                if (drainDone) begin
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                busyComb  = 1'b1;
                wrEnComb  = 1'b1;
                stateNext = (rowCnt == LAST_ROW) ? DONE : LOAD;
            end
            DONE: begin
                doneComb  = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Row, column and drain counters; they move only on FSM transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            rowCnt    <= '0;
            colCnt    <= '0;
            drainDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rowCnt <= '0;
                        colCnt <= '0;
                    end
                end
                LOAD: begin
                    colCnt <= '0;
                end
                STREAM: begin
                    drainDone <= 1'b0;
                    if (colCnt != LAST_COL) begin
                        colCnt <= colCnt + LOG_OUTPUT_FEATURES'(1);
                    end
                end
                DRAIN: begin
                    drainDone <= 1'b1;
                end
                WRITE: begin
                    if (rowCnt != LAST_ROW) begin
                        rowCnt <= rowCnt + LOG_BATCH_SIZE'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // p0: weight address presented this cycle while streaming.
    assign vld_p0 = (state == STREAM);

    // Valid bits follow the column index down the read and multiply stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Column index tags travel with the data; no reset needed.
    always_ff @(posedge clk) begin
        col_p1 <= colCnt;
        col_p2 <= col_p1;
    end

    // p1 -> p2: memory data in, registered dot product out.
    dot_product_unit #(
        .INPUT_FEATURES     (INPUT_FEATURES),
        .LOG_INPUT_FEATURES (LOG_INPUT_FEATURES),
        .INPUT_WIDTH        (INPUT_WIDTH),
        .WEIGHT_WIDTH       (WEIGHT_WIDTH)
    ) dpu (
        .clk       (clk),
        .inputRow  (bus.inputData),
        .weightRow (bus.weightData),
        .dotSum    (dotSum_p2)
    );

    assign sumExt_p2 = 64'(dotSum_p2);
    assign elem_p2   = OUTPUT_WIDTH'(reduceSum(sumExt_p2, OUTPUT_WIDTH));

    // Row buffer: each valid p2 result overwrites its column slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rowBuf <= '0;
        end else if (vld_p2) begin
            rowBuf[col_p2*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= elem_p2;
        end
    end

    assign bus.busy       = busyComb;
    assign bus.done       = doneComb;
    assign bus.outputWrEn = wrEnComb;
    assign bus.inputAddr  = rowCnt;
    assign bus.outputAddr = rowCnt;
    assign bus.weightAddr = colCnt;
    assign bus.outputData = rowBuf;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: two instances (16-bit and 12-bit outputs)
// share clock, reset and memory contents; results are compared against
// hand-computed tables and a plain-arithmetic matrix product.
module tb_matmul_sequencer;

    localparam int M   = 8;
    localparam int N   = 4;
    localparam int O   = 8;
    localparam int IW  = 4;
    localparam int WW  = 8;
    localparam int OW0 = 16;
    localparam int OW1 = 12;
    localparam int AW  = N * IW;
    localparam int BW  = N * WW;
    localparam int ROWCYC   = O + 4;
    localparam int DONE_CYC = M * ROWCYC + 1;

`ifdef MATMUL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.OUTPUT_WIDTH(OW0)) m0 ();
    matmul_sequencer_if #(.OUTPUT_WIDTH(OW1)) m1 ();

    matmul_sequencer #(.OUTPUT_WIDTH(OW0)) dut0 (.clk(clk), .rst(rst), .bus(m0));
    matmul_sequencer #(.OUTPUT_WIDTH(OW1)) dut1 (.clk(clk), .rst(rst), .bus(m1));

    logic [AW-1:0] aMem [M];
    logic [BW-1:0] bMem [O];

    // Synchronous-read memories, one read port per instance.
    always @(posedge clk) begin
        m0.inputData  <= aMem[m0.inputAddr];
        m0.weightData <= bMem[m0.weightAddr];
        m1.inputData  <= aMem[m1.inputAddr];
        m1.weightData <= bMem[m1.weightAddr];
    end

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    int  t0 = 0;
    bit  monOn = 1'b0;
    bit  addrChk = 1'b0;
    int  wrCount = 0, wr1Count = 0, doneCount = 0, lastDoneTick = 0, addrErr = 0;
    int  mRel, mRow, mPh;
    logic [O*OW0-1:0] c0 [M];
    logic [O*OW1-1:0] c1 [M];

    // Output-memory capture and cycle-exact timing/address monitor.
    always @(negedge clk) begin
        if (m0.outputWrEn) begin
            wrCount++;
            c0[m0.outputAddr] = m0.outputData;
        end
        if (m1.outputWrEn) begin
            wr1Count++;
            c1[m1.outputAddr] = m1.outputData;
        end
        if (m0.done) begin
            doneCount++;
            lastDoneTick = tick;
        end
        if (monOn && addrChk) begin
            mRel = tick - t0;
            if (mRel >= 1 && mRel <= M * ROWCYC) begin
                mRow = (mRel - 1) / ROWCYC;
                mPh  = (mRel - 1) % ROWCYC;
                if (int'(m0.inputAddr) != mRow) addrErr++;
                if (mPh >= 1 && mPh <= O && int'(m0.weightAddr) != mPh - 1) addrErr++;
                if (m0.outputWrEn != (mPh == ROWCYC - 1)) addrErr++;
                if (mPh == ROWCYC - 1 && int'(m0.outputAddr) != mRow) addrErr++;
                if (!m0.busy) addrErr++;
                if (m0.done) addrErr++;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    endtask

    // Reference: plain signed dot product of A row r with B-transpose row o.
    function automatic longint dotRef(input int r, input int o);
        longint s;
        logic signed [IW-1:0] a;
        logic signed [WW-1:0] b;
        s = 0;
        for (int k = 0; k < N; k++) begin
            a = aMem[r][k*IW +: IW];
            b = bMem[o][k*WW +: WW];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    // Reference: reduce to w bits (clamp or two's-complement wrap).
    function automatic longint reduceRef(input longint s, input int w);
        longint hi, lo, span, m;
        span = longint'(1) << w;
        hi   = (span >> 1) - 1;
        lo   = -(span >> 1);
        if (SAT) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        m = s & (span - 1);
        if (m > hi) m -= span;
        return m;
    endfunction

    int wrBase, wr1Base, doneBase, errBase;

    task automatic setBases();
        wrBase   = wrCount;
        wr1Base  = wr1Count;
        doneBase = doneCount;
        errBase  = addrErr;
    endtask

    task automatic launch(input bit chk);
        @(posedge clk); #1;
        setBases();
        t0       = tick;
        addrChk  = chk;
        monOn    = 1'b1;
        m0.start = 1'b1;
        m1.start = 1'b1;
        @(posedge clk); #1;
        m0.start = 1'b0;
        m1.start = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200 && doneCount == doneBase; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        monOn = 1'b0;
    endtask

    task automatic checkRun(input string tag);
        check({tag, " writes"}, wrCount - wrBase, M);
        check({tag, " writes12"}, wr1Count - wr1Base, M);
        check({tag, " done pulses"}, doneCount - doneBase, 1);
        check({tag, " done cycle"}, lastDoneTick - t0, DONE_CYC);
        check({tag, " addr/timing errors"}, addrErr - errBase, 0);
    endtask

    task automatic checkModel(input string tag);
        int bad0, bad1;
        logic signed [OW0-1:0] e0;
        logic signed [OW1-1:0] e1;
        bad0 = 0;
        bad1 = 0;
        for (int r = 0; r < M; r++) begin
            for (int o = 0; o < O; o++) begin
                e0 = c0[r][o*OW0 +: OW0];
                e1 = c1[r][o*OW1 +: OW1];
                if (longint'(e0) != reduceRef(dotRef(r, o), OW0)) bad0++;
                if (longint'(e1) != reduceRef(dotRef(r, o), OW1)) bad1++;
            end
        end
        check({tag, " model C16 bad elems"}, bad0, 0);
        check({tag, " model C12 bad elems"}, bad1, 0);
    endtask

    task automatic loadUniform(input int aVal, input int bBase, input int bStep);
        for (int r = 0; r < M; r++)
            for (int k = 0; k < N; k++)
                aMem[r][k*IW +: IW] = IW'(aVal);
        for (int o = 0; o < O; o++)
            for (int k = 0; k < N; k++)
                bMem[o][k*WW +: WW] = WW'(bBase + o * bStep);
    endtask

    task automatic loadRandom();
        for (int r = 0; r < M; r++) aMem[r] = AW'($urandom);
        for (int o = 0; o < O; o++) bMem[o] = BW'($urandom);
    endtask

    typedef struct {
        int aVal;
        int bBase;
        int bStep;
        int e16Base;
        int e16Step;
        int e12Base;
        int e12Step;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad16, bad12, wrAtRst;
        logic signed [OW0-1:0] el16;
        logic signed [OW1-1:0] el12;

        vecs[0] = '{1,   0,    1, 0,     4,  0,                4};
        vecs[1] = '{-8, -128,  0, 4096,  0,  SAT ? 2047 : 0,    0};
        vecs[2] = '{-8,  127,  0, -4064, 0,  SAT ? -2048 : 32,  0};
        vecs[3] = '{7,   127,  0, 3556,  0,  SAT ? 2047 : -540, 0};
        vecs[4] = '{7,  -128,  0, -3584, 0,  SAT ? -2048 : 512, 0};
        vecs[5] = '{-1, -4,    1, 16,   -4,  16,               -4};

        m0.start = 1'b0;
        m1.start = 1'b0;
        loadUniform(0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", m0.busy, 0);
        check("reset done", m0.done, 0);
        check("reset outputWrEn", m0.outputWrEn, 0);
        check("reset inputAddr", m0.inputAddr, 0);
        check("reset weightAddr", m0.weightAddr, 0);
        check("reset outputAddr", m0.outputAddr, 0);
        check("reset outputData nonzero", longint'(m0.outputData != '0), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            loadUniform(vecs[i].aVal, vecs[i].bBase, vecs[i].bStep);
            launch(1'b1);
            waitDone();
            checkRun($sformatf("vec%0d", i));
            bad16 = 0;
            bad12 = 0;
            for (int r = 0; r < M; r++) begin
                for (int o = 0; o < O; o++) begin
                    el16 = c0[r][o*OW0 +: OW0];
                    el12 = c1[r][o*OW1 +: OW1];
                    if (int'(el16) != vecs[i].e16Base + o * vecs[i].e16Step) bad16++;
                    if (int'(el12) != vecs[i].e12Base + o * vecs[i].e12Step) bad12++;
                end
            end
            check($sformatf("vec%0d table C16 bad elems", i), bad16, 0);
            check($sformatf("vec%0d table C12 bad elems", i), bad12, 0);
            checkModel($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            loadRandom();
            launch(1'b1);
            waitDone();
            checkRun($sformatf("rand%0d", i));
            checkModel($sformatf("rand%0d", i));
        end

        // Start pulsed again at cycle 5 must be ignored.
        loadUniform(1, 0, 1);
        launch(1'b1);
        repeat (4) @(posedge clk);
        #1;
        m0.start = 1'b1;
        m1.start = 1'b1;
        @(posedge clk); #1;
        m0.start = 1'b0;
        m1.start = 1'b0;
        waitDone();
        checkRun("startBusy");
        repeat (20) @(posedge clk);
        #1;
        check("startBusy no extra writes", wrCount - wrBase, M);
        check("startBusy idle after", m0.busy, 0);

        // Reset asserted during cycle 30 of a multiply.
        loadRandom();
        launch(1'b0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        wrAtRst = wrCount - wrBase;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midRst writes before reset", wrAtRst, 2);
        check("midRst busy", m0.busy, 0);
        check("midRst outputWrEn", m0.outputWrEn, 0);
        check("midRst inputAddr", m0.inputAddr, 0);
        check("midRst weightAddr", m0.weightAddr, 0);
        check("midRst outputData nonzero", longint'(m0.outputData != '0), 0);
        repeat (100) @(posedge clk);
        #1;
        monOn = 1'b0;
        check("midRst writes after reset", wrCount - wrBase, 2);
        check("midRst done pulses", doneCount - doneBase, 0);
        launch(1'b1);
        waitDone();
        checkRun("afterRst");
        checkModel("afterRst");

        // Reset and start in the same cycle: reset wins.
        @(posedge clk); #1;
        setBases();
        rst      = 1'b1;
        m0.start = 1'b1;
        m1.start = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        m0.start = 1'b0;
        m1.start = 1'b0;
        check("rstStart busy", m0.busy, 0);
        repeat (30) @(posedge clk);
        #1;
        check("rstStart writes", wrCount - wrBase, 0);
        check("rstStart busy later", m0.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control FSM and compute pipeline for the [M×N]·[N×O] matrix multiply engine. Reads one row of A and, per output column, one row of Bᵀ from synchronous-read memories. Computes one dot product per cycle, collects the O results of a row into a row buffer and writes that row of C to output memory. Sits between the A/Bᵀ/C memories and the host control, which only issues `start` and waits for `done`.

## Interface
Parameters:
- BATCH_SIZE, 8, rows of A and C (M)
- LOG_BATCH_SIZE, 3, log2(BATCH_SIZE)
- INPUT_FEATURES, 4, inner dimension (N)
- LOG_INPUT_FEATURES, 2, log2(INPUT_FEATURES)
- OUTPUT_FEATURES, 8, columns of C (O)
- LOG_OUTPUT_FEATURES, 3, log2(OUTPUT_FEATURES)
- INPUT_WIDTH, 4, signed A element width
- WEIGHT_WIDTH, 8, signed B element width
- OUTPUT_WIDTH, 16, signed C element width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a full multiply; ignored unless idle
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse after the last row is written
- inputAddr  out  LOG_BATCH_SIZE  row of A being read
- inputData  in  INPUT_FEATURES*INPUT_WIDTH  A row; lane k = bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- weightAddr  out  LOG_OUTPUT_FEATURES  row of Bᵀ (column o of B)
- weightData  in  INPUT_FEATURES*WEIGHT_WIDTH  Bᵀ row, same lane packing
- outputData  out  OUTPUT_FEATURES*OUTPUT_WIDTH  row buffer; element o at [o*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- outputAddr  out  LOG_BATCH_SIZE  C row being written
- outputWrEn  out  1  one-cycle write strobe

## Operation
- Memories: read data is valid exactly one cycle after the address is presented.
- States are IDLE, LOAD, STREAM, DRAIN, WRITE and DONE.
- IDLE: on `start`, set row m=0 and go to LOAD.
- LOAD (1 cycle): drive inputAddr=m. inputAddr holds m for the whole row.
- STREAM (O cycles): weightAddr = o = 0..O-1, one per cycle.
- DRAIN (2 cycles): flush the read and dot-product pipeline.
- WRITE (1 cycle):
  - assert outputWrEn with outputAddr=m.
  - if m==M-1, go to DONE; else m+1 and go to LOAD.
- DONE (1 cycle): pulse `done`, then return to IDLE.
- Dot product: sum over k of signed(inputData[k])·signed(weightData[k]).
  - products are INPUT_WIDTH+WEIGHT_WIDTH bits.
  - the sum is INPUT_WIDTH+WEIGHT_WIDTH+LOG_INPUT_FEATURES bits, full precision, no intermediate overflow.
  - it is reduced to OUTPUT_WIDTH per Configuration.
- The result for column o is written into row-buffer slot o. Slots are not cleared between rows; every slot is overwritten each row.
- `start` while busy is ignored and has no effect.
- Counters o and m wrap only through explicit FSM transitions. No address beyond O-1 or M-1 is ever driven.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, outputWrEn=0
  - inputAddr=0, weightAddr=0, outputAddr=0, outputData=0
- Start accepted at cycle 0:
  - LOAD occurs at cycle 1.
  - weightAddr=o is presented at cycle 2+o.
  - weightData for o is valid at cycle 3+o.
  - the dot-product register holds column o at cycle 4+o; the row-buffer slot is written at the following edge.
- Per row: 1+O+2+1 = O+4 cycles. With defaults, the first outputWrEn is at cycle 12.
- Whole multiply: `done` at cycle M·(O+4)+1, which is 97 with defaults.
- outputData is stable during the outputWrEn cycle and holds until overwritten.
- rst mid-operation: next cycle is IDLE with all outputs at reset values. No partial write and no `done`.
- rst and `start` in the same cycle: rst wins.

## Configuration
- MATMUL_SAT_EN defined: the full-precision sum is clamped to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
- MATMUL_SAT_EN undefined: the low OUTPUT_WIDTH bits are kept (two's-complement wrap).
- If the full sum width ≤ OUTPUT_WIDTH, both modes sign-extend and are identical.

## Structure
- Shared package `matmul_pkg`:
  - FSM state enum
  - PROD_WIDTH and SUM_WIDTH constants
  - reduce-to-OUTPUT_WIDTH function (saturate/wrap)
- Sub-module `dot_product_unit`: N signed multipliers, adder tree, one output register (1-cycle latency).
- The sequencer owns the FSM, counters, address regs and row buffer.

## Test plan
- Identity test (defaults): A all 1s, Bᵀ row o = {o,o,o,o} → every C row = {0,4,8,...,28}; outputWrEn at cycles 12, 24, …, 96; done at 97.
- Signed test: A row = {-8,-8,-8,-8}, Bᵀ rows = {-128,…} → each element 4096; then Bᵀ {127,…} → -4064.
- Saturation test (OUTPUT_WIDTH=12, same -8·-128 data): with MATMUL_SAT_EN each element = 2047; without it = 4096 mod 4096 = 0.
- Start while busy: pulse `start` at cycles 0 and 5 → exactly 8 writes and one `done` at cycle 97.
- Reset mid-op: assert rst at cycle 30 → no outputWrEn afterwards, busy=0 at cycle 31; a fresh start then completes normally.
- Address sweep: check weightAddr sequence 0..7 and inputAddr/outputAddr equal to m for all 8 rows; no out-of-range address.
